// File: rtl/ksa_pkg.sv
// Shared types and sizing for the RC4 key-scheduling swap loop.
package ksa_pkg;

    localparam int unsigned KEY_BYTES   = 3;
    localparam int unsigned S_SIZE      = 256;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned KEY_W       = 8 * KEY_BYTES;
    localparam int unsigned MEM_LAT_DEF = 2;

    typedef enum logic [3:0] {
        IDLE,
        RD_I,
        LAT_I,
        RD_J,
        LAT_J,
        WR_I,
        WR_J,
        NEXT,
        DONE
    } ksa_state_t;

endpackage

// File: rtl/ksa_swap_loop.sv
// RC4 KSA second pass: walks i over the S-memory, accumulates j and swaps S[i]/S[j].
module ksa_swap_loop
    import ksa_pkg::*;
#(
    parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [KEY_W-1:0]    secret_key,
    input  logic [DATA_W-1:0]   q,
    output logic [ADDR_W-1:0]   addr_two,
    output logic [DATA_W-1:0]   data_in_two,
    output logic                wren_2,
    output logic                loop_2_done
);

    localparam int unsigned WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [WAIT_W-1:0] LAT_LAST = WAIT_W'(MEM_LAT - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(S_SIZE - 1);

    ksa_state_t          state, state_nxt;
    logic [ADDR_W-1:0]   i, i_nxt;
    logic [ADDR_W-1:0]   j, j_nxt;
    logic [1:0]          kidx, kidx_nxt;
    logic [DATA_W-1:0]   si, si_nxt;
    logic [DATA_W-1:0]   sj, sj_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   data_nxt;
    logic                wren_nxt;
    logic                done_nxt;
    logic [DATA_W-1:0]   key_byte_c;
    logic [ADDR_W-1:0]   j_sum_c;

    // Key byte i mod 3: byte 0 is the most significant
    always_comb begin
        key_byte_c = secret_key[7:0];
        case (kidx)
            2'd0:    key_byte_c = secret_key[23:16];
            2'd1:    key_byte_c = secret_key[15:8];
            default: key_byte_c = secret_key[7:0];
        endcase
    end

    assign j_sum_c = j + q + key_byte_c;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            i           <= '0;
            j           <= '0;
            kidx        <= '0;
            si          <= '0;
            sj          <= '0;
            wait_cnt    <= '0;
            addr_two    <= '0;
            data_in_two <= '0;
            wren_2      <= 1'b0;
            loop_2_done <= 1'b0;
        end else begin
            state       <= state_nxt;
            i           <= i_nxt;
            j           <= j_nxt;
            kidx        <= kidx_nxt;
            si          <= si_nxt;
            sj          <= sj_nxt;
            wait_cnt    <= wait_nxt;
            addr_two    <= addr_nxt;
            data_in_two <= data_nxt;
            wren_2      <= wren_nxt;
            loop_2_done <= done_nxt;
        end
    end

    // Outputs are set on the transition into a state so they are valid for its whole duration
    always_comb begin
        state_nxt = state;
        i_nxt     = i;
        j_nxt     = j;
        kidx_nxt  = kidx;
        si_nxt    = si;
        sj_nxt    = sj;
        wait_nxt  = wait_cnt;
        addr_nxt  = addr_two;
        data_nxt  = data_in_two;
        wren_nxt  = 1'b0;
        done_nxt  = loop_2_done;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RD_I;
                    i_nxt     = '0;
                    j_nxt     = '0;
                    kidx_nxt  = '0;
                    wait_nxt  = '0;
                    addr_nxt  = '0;
                end
            end
            RD_I: begin
                if (wait_cnt == LAT_LAST) begin
                    wait_nxt  = '0;
                    state_nxt = LAT_I;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            LAT_I: begin
                si_nxt    = q;
                j_nxt     = j_sum_c;
                addr_nxt  = j_sum_c;
                state_nxt = RD_J;
            end
            RD_J: begin
                if (wait_cnt == LAT_LAST) begin
                    wait_nxt  = '0;
                    state_nxt = LAT_J;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            LAT_J: begin
                sj_nxt    = q;
                addr_nxt  = i;
                data_nxt  = q;
                wren_nxt  = 1'b1;
                state_nxt = WR_I;
            end
            WR_I: begin
                addr_nxt  = j;
                data_nxt  = si;
                wren_nxt  = 1'b1;
                state_nxt = WR_J;
            end
            WR_J: begin
                state_nxt = NEXT;
            end
            NEXT: begin
                if (i == LAST_IDX) begin
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    i_nxt     = i + ADDR_W'(1);
                    kidx_nxt  = (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
                    addr_nxt  = i + ADDR_W'(1);
                    wait_nxt  = '0;
                    state_nxt = RD_I;
                end
            end
            DONE: begin
                done_nxt = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ksa_swap_loop.sv
// Directed bench for ksa_swap_loop with a two-stage S-memory model.
module tb_ksa_swap_loop;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  q;
    logic [7:0]  addr_two;
    logic [7:0]  data_in_two;
    logic        wren_2;
    logic        loop_2_done;

    logic        init_req;
    logic [7:0]  mem [256];
    logic [7:0]  m_addr;
    logic [7:0]  m_data;
    logic        m_wren;

    logic [7:0]  ref_s  [256];
    logic [7:0]  exp_wa [512];
    logic [7:0]  exp_wd [512];
    logic [7:0]  wr_addr [512];
    logic [7:0]  wr_data [512];
    int          nw;
    int          n_checks;
    int          n_pass;

    ksa_swap_loop #(.MEM_LAT(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .secret_key  (secret_key),
        .q           (q),
        .addr_two    (addr_two),
        .data_in_two (data_in_two),
        .wren_2      (wren_2),
        .loop_2_done (loop_2_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Port-mux register followed by a RAM with registered read data
    always @(posedge clk) begin
        m_addr <= addr_two;
        m_data <= data_in_two;
        m_wren <= wren_2;
        if (init_req) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else if (m_wren) begin
            mem[m_addr] <= m_data;
        end
        q <= mem[m_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Software KSA on identity S, recording the expected write stream
    task automatic build_ref(input logic [23:0] key);
        logic [7:0] s [256];
        logic [7:0] jj, t, kb;
        for (int k = 0; k < 256; k++) s[k] = 8'(k);
        jj = 8'd0;
        for (int ii = 0; ii < 256; ii++) begin
            kb = (ii % 3 == 0) ? key[23:16] : (ii % 3 == 1) ? key[15:8] : key[7:0];
            jj = jj + s[ii] + kb;
            exp_wa[2*ii]   = 8'(ii);
            exp_wd[2*ii]   = s[jj];
            exp_wa[2*ii+1] = jj;
            exp_wd[2*ii+1] = s[ii];
            t      = s[ii];
            s[ii]  = s[jj];
            s[jj]  = t;
        end
        for (int k = 0; k < 256; k++) ref_s[k] = s[k];
    endtask

    task automatic init_mem();
        @(negedge clk); init_req = 1'b1;
        @(negedge clk); init_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Pulse start for one cycle and run; abort_at >= 0 asserts reset on that write pulse
    task automatic run_key(input logic [23:0] key, input int abort_at,
                           output int cyc, output bit aborted);
        secret_key = key;
        build_ref(key);
        nw = 0;
        aborted = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!loop_2_done && cyc < 3000) begin
            if (wren_2) begin
                if (nw == abort_at) begin
                    check("abort_addr", 32'(addr_two), 32'd100);
                    reset_n = 1'b0;
                    aborted = 1'b1;
                    break;
                end
                if (nw < 512) begin
                    wr_addr[nw] = addr_two;
                    wr_data[nw] = data_in_two;
                end
                nw++;
            end
            @(negedge clk);
            cyc++;
        end
        if (!aborted && !loop_2_done) check("done_timeout", 32'(cyc), 32'd2304);
    endtask

    task automatic check_run(input string tag);
        int errs;
        errs = 0;
        for (int k = 0; k < 512; k++)
            if (k >= nw || wr_addr[k] !== exp_wa[k] || wr_data[k] !== exp_wd[k]) errs++;
        check({tag, "_write_seq_errs"}, 32'(errs), 32'd0);
        check({tag, "_write_cnt"}, 32'(nw), 32'd512);
        errs = 0;
        for (int k = 0; k < 256; k++)
            if (mem[k] !== ref_s[k]) errs++;
        check({tag, "_final_s_errs"}, 32'(errs), 32'd0);
    endtask

    initial begin
        int  cyc;
        int  bad;
        bit  aborted;
        n_checks   = 0;
        n_pass     = 0;
        reset_n    = 1'b0;
        start      = 1'b1;
        secret_key = 24'h0;
        init_req   = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_addr", 32'(addr_two), 32'd0);
        check("rst_data", 32'(data_in_two), 32'd0);
        check("rst_wren", 32'(wren_2), 32'd0);
        check("rst_done", 32'(loop_2_done), 32'd0);

        start   = 1'b0;
        reset_n = 1'b1;
        init_mem();
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (wren_2 || loop_2_done || addr_two != 8'd0 || data_in_two != 8'd0) bad++;
        end
        check("idle_quiet", 32'(bad), 32'd0);

        // Key 0: i==j on the first two iterations, then S[2]/S[3] swap
        run_key(24'h000000, -1, cyc, aborted);
        check("k0_cycles", 32'(cyc), 32'd2304);
        check("k0_w0_addr", 32'(wr_addr[0]), 32'd0);
        check("k0_w1_addr", 32'(wr_addr[1]), 32'd0);
        check("k0_w1_data", 32'(wr_data[1]), 32'd0);
        check("k0_w4_addr", 32'(wr_addr[4]), 32'd2);
        check("k0_w4_data", 32'(wr_data[4]), 32'd3);
        check("k0_w5_addr", 32'(wr_addr[5]), 32'd3);
        check("k0_w5_data", 32'(wr_data[5]), 32'd2);
        check_run("k0");

        start = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b0;
        check("done_held", 32'(loop_2_done), 32'd1);
        check("done_no_wr", 32'(wren_2), 32'd0);

        // Reset mid-run during iteration 100 first write
        reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        init_mem();
        run_key(24'h000249, 200, cyc, aborted);
        check("abort_seen", 32'(aborted), 32'd1);
        @(negedge clk);
        check("abort_wren", 32'(wren_2), 32'd0);
        check("abort_done", 32'(loop_2_done), 32'd0);
        check("abort_addr_rst", 32'(addr_two), 32'd0);
        reset_n = 1'b1;
        init_mem();

        run_key(24'h000249, -1, cyc, aborted);
        check("k249_cycles", 32'(cyc), 32'd2304);
        check("k249_w2_addr", 32'(wr_addr[2]), 32'd1);
        check("k249_w2_data", 32'(wr_data[2]), 32'd3);
        check("k249_w3_addr", 32'(wr_addr[3]), 32'd3);
        check("k249_w3_data", 32'(wr_data[3]), 32'd1);
        check_run("k249");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
